// File: rtl/data_mem_lat.sv
// data_mem_lat: little-endian byte-addressed data memory with a yumi/valid handshake,
// configurable response latency, sign/zero-extended loads and saturating error count.
`default_nettype none

module data_mem_lat #(
   parameter int addr_width_p = 12,
   parameter int latency_p    = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid_i,
   input  logic        req_wen_i,
   input  logic [1:0]  req_size_i,
   input  logic        req_signed_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] wdata_i,
   output logic        req_yumi_o,
   output logic        resp_valid_o,
   output logic [31:0] resp_rdata_o,
   output logic        resp_err_o,
   input  logic        resp_yumi_i,
   output logic [15:0] err_count_o
);

   localparam int CNT_W = (latency_p > 1) ? $clog2(latency_p) : 1;
   localparam int DEPTH = 2 ** addr_width_p;
   localparam logic [addr_width_p-1:0] A_ONE   = addr_width_p'(1);
   localparam logic [addr_width_p-1:0] A_TWO   = addr_width_p'(2);
   localparam logic [addr_width_p-1:0] A_THREE = addr_width_p'(3);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t            state;
   logic [CNT_W-1:0]  cnt;
   logic [7:0]        mem [DEPTH];
   logic [31:0]       pend_rdata;
   logic              pend_err;
   logic [15:0]       err_cnt;

   logic [addr_width_p-1:0] a0, a1, a2, a3;
   logic [7:0]              b0, b1, b2, b3;
   logic                    bad_size, misaligned, out_of_bounds, req_err;
   logic [31:0]             load_data, rdata_next;

   assign req_yumi_o  = req_valid_i & (state == IDLE);
   assign err_count_o = err_cnt;

   always_comb begin
      a0 = addr_i[addr_width_p-1:0];
      a1 = a0 + A_ONE;
      a2 = a0 + A_TWO;
      a3 = a0 + A_THREE;
      b0 = mem[a0];
      b1 = mem[a1];
      b2 = mem[a2];
      b3 = mem[a3];

      bad_size      = (req_size_i == 2'b11);
      misaligned    = ((req_size_i == 2'b01) & addr_i[0]) |
                      ((req_size_i == 2'b10) & (addr_i[1:0] != 2'b00));
      out_of_bounds = ((addr_i >> addr_width_p) != 32'd0);
      req_err       = bad_size | misaligned | out_of_bounds;

      case (req_size_i)
         2'b00:   load_data = {{24{req_signed_i & b0[7]}}, b0};
         2'b01:   load_data = {{16{req_signed_i & b1[7]}}, b1, b0};
         default: load_data = {b3, b2, b1, b0};
      endcase

      rdata_next = (req_wen_i | req_err) ? 32'd0 : load_data;
   end

   // Storage has no reset; a store commits on its acceptance edge.
   always_ff @(posedge clk) begin
      if (req_yumi_o && !req_err && req_wen_i && !reset) begin
         mem[a0] <= wdata_i[7:0];
         if (req_size_i != 2'b00) begin
            mem[a1] <= wdata_i[15:8];
         end
         if (req_size_i == 2'b10) begin
            mem[a2] <= wdata_i[23:16];
            mem[a3] <= wdata_i[31:24];
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         cnt          <= '0;
         resp_valid_o <= 1'b0;
         resp_rdata_o <= 32'd0;
         resp_err_o   <= 1'b0;
         err_cnt      <= 16'd0;
         pend_rdata   <= 32'd0;
         pend_err     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid_i) begin
                  pend_rdata <= rdata_next;
                  pend_err   <= req_err;
                  if (latency_p == 1) begin
                     state        <= RESP;
                     resp_valid_o <= 1'b1;
                     resp_rdata_o <= rdata_next;
                     resp_err_o   <= req_err;
                  end else begin
                     state <= WAIT;
                     cnt   <= CNT_W'(latency_p - 1);
                  end
               end
            end
            WAIT: begin
               if (cnt == CNT_W'(1)) begin
                  state        <= RESP;
                  resp_valid_o <= 1'b1;
                  resp_rdata_o <= pend_rdata;
                  resp_err_o   <= pend_err;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            RESP: begin
               if (resp_yumi_i) begin
                  state        <= IDLE;
                  resp_valid_o <= 1'b0;
                  resp_rdata_o <= 32'd0;
                  resp_err_o   <= 1'b0;
                  if (resp_err_o && (err_cnt != 16'hFFFF)) begin
                     err_cnt <= err_cnt + 16'd1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_data_mem_lat.sv
// Scoreboard bench for data_mem_lat: one instance at latency 1, one at latency 4.
`default_nettype none

module tb_data_mem_lat;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  req_valid, resp_yumi, req_yumi, resp_valid, resp_err;
   logic        req_wen, req_signed;
   logic [1:0]  req_size;
   logic [31:0] addr, wdata;
   logic [31:0] rdata [2];
   logic [15:0] errc  [2];

   int n_checks = 0;
   int n_pass   = 0;

   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
   } exp_t;
   exp_t sb[$];

   always #5 clk = ~clk;

   data_mem_lat #(.addr_width_p(12), .latency_p(1)) dut1 (
      .clk(clk), .reset(reset), .req_valid_i(req_valid[0]), .req_wen_i(req_wen),
      .req_size_i(req_size), .req_signed_i(req_signed), .addr_i(addr), .wdata_i(wdata),
      .req_yumi_o(req_yumi[0]), .resp_valid_o(resp_valid[0]), .resp_rdata_o(rdata[0]),
      .resp_err_o(resp_err[0]), .resp_yumi_i(resp_yumi[0]), .err_count_o(errc[0])
   );

   data_mem_lat #(.addr_width_p(12), .latency_p(4)) dut4 (
      .clk(clk), .reset(reset), .req_valid_i(req_valid[1]), .req_wen_i(req_wen),
      .req_size_i(req_size), .req_signed_i(req_signed), .addr_i(addr), .wdata_i(wdata),
      .req_yumi_o(req_yumi[1]), .resp_valid_o(resp_valid[1]), .resp_rdata_o(rdata[1]),
      .resp_err_o(resp_err[1]), .resp_yumi_i(resp_yumi[1]), .err_count_o(errc[1])
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   // One full transaction on instance s: drive, accept, await response, optionally hold, consume.
   task automatic issue(input int s, input logic wen, input logic [1:0] size, input logic sgn,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] exp_rdata, input logic exp_err,
                        input int lat, input int hold, input bit keep);
      exp_t e;
      int   cyc;
      req_wen    = wen;
      req_size   = size;
      req_signed = sgn;
      addr       = a;
      wdata      = wd;
      req_valid[s] = 1'b1;
      sb.push_back('{rdata: exp_rdata, err: exp_err});
      #1 check("yumi_idle", req_yumi[s], 1);
      @(posedge clk);
      @(negedge clk);
      if (!keep) req_valid[s] = 1'b0;
      cyc = 1;
      while (!resp_valid[s] && cyc < 40) begin
         if (keep) check("yumi_busy", req_yumi[s], 0);
         @(negedge clk);
         cyc++;
      end
      check("latency", cyc, lat);
      e = sb.pop_front();
      check("rdata", rdata[s], e.rdata);
      check("err", resp_err[s], e.err);
      repeat (hold) begin
         @(negedge clk);
         check("hold_valid", resp_valid[s], 1);
         check("hold_rdata", rdata[s], e.rdata);
         if (keep) check("yumi_resp", req_yumi[s], 0);
      end
      resp_yumi[s] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      resp_yumi[s] = 1'b0;
      check("consumed", resp_valid[s], 0);
      if (keep) begin
         check("next_accept", req_yumi[s], 1);
         req_valid[s] = 1'b0;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      reset = 1'b1;
      req_valid = 2'b00;
      resp_yumi = 2'b00;
      req_wen = 1'b0;
      req_signed = 1'b0;
      req_size = 2'b00;
      addr = 32'd0;
      wdata = 32'd0;
      repeat (2) @(negedge clk);
      check("rst_valid", resp_valid[0], 0);
      check("rst_rdata", rdata[0], 0);
      check("rst_err", resp_err[0], 0);
      check("rst_errc", errc[0], 0);
      check("rst_yumi", req_yumi[0], 0);
      reset = 1'b0;
      @(negedge clk);

      // latency 1: stores, loads, extension
      issue(0, 1, 2'b10, 0, 32'h010, 32'hDEADBEEF, 32'h0, 0, 1, 0, 0);
      issue(0, 1, 2'b10, 0, 32'h000, 32'h11223344, 32'h0, 0, 1, 0, 0);
      issue(0, 0, 2'b10, 0, 32'h010, 32'h0, 32'hDEADBEEF, 0, 1, 0, 0);
      issue(0, 0, 2'b00, 1, 32'h013, 32'h0, 32'hFFFFFFDE, 0, 1, 0, 0);
      issue(0, 0, 2'b00, 0, 32'h013, 32'h0, 32'h000000DE, 0, 1, 0, 0);
      issue(0, 0, 2'b01, 1, 32'h010, 32'h0, 32'hFFFFBEEF, 0, 1, 0, 0);
      issue(0, 0, 2'b01, 0, 32'h012, 32'h0, 32'h0000DEAD, 0, 1, 0, 0);
      issue(0, 0, 2'b00, 1, 32'h011, 32'h0, 32'hFFFFFFBE, 0, 1, 0, 0);
      issue(0, 1, 2'b00, 0, 32'h012, 32'hFFFFFF55, 32'h0, 0, 1, 0, 0);
      issue(0, 0, 2'b10, 1, 32'h010, 32'h0, 32'hDE55BEEF, 0, 1, 0, 0);

      // error cases
      issue(0, 1, 2'b10, 0, 32'h011, 32'hCAFEF00D, 32'h0, 1, 1, 0, 0);
      issue(0, 0, 2'b01, 1, 32'h001, 32'h0, 32'h0, 1, 1, 0, 0);
      issue(0, 0, 2'b11, 0, 32'h010, 32'h0, 32'h0, 1, 1, 0, 0);
      issue(0, 1, 2'b10, 0, 32'h1000, 32'hCAFEF00D, 32'h0, 1, 1, 0, 0);
      check("errc_4", errc[0], 16'd4);
      issue(0, 0, 2'b10, 0, 32'h010, 32'h0, 32'hDE55BEEF, 0, 1, 0, 0);
      issue(0, 0, 2'b10, 0, 32'h000, 32'h0, 32'h11223344, 0, 1, 0, 0);

      // saturation
      force dut1.err_cnt = 16'hFFFF;
      #1 release dut1.err_cnt;
      check("errc_forced", errc[0], 16'hFFFF);
      issue(0, 0, 2'b11, 0, 32'h000, 32'h0, 32'h0, 1, 1, 0, 0);
      check("errc_sat", errc[0], 16'hFFFF);

      // latency 4, held response, request held valid
      issue(1, 1, 2'b10, 0, 32'h020, 32'hA5A50F0F, 32'h0, 0, 4, 0, 0);
      issue(1, 0, 2'b10, 0, 32'h020, 32'h0, 32'hA5A50F0F, 0, 4, 3, 1);
      issue(1, 0, 2'b01, 0, 32'h021, 32'h0, 32'h0, 1, 4, 0, 0);
      check("errc4_1", errc[1], 16'd1);

      // asynchronous reset while waiting
      req_wen = 1'b0;
      req_size = 2'b10;
      req_signed = 1'b0;
      addr = 32'h020;
      req_valid[1] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req_valid[1] = 1'b0;
      check("wait_valid", resp_valid[1], 0);
      #2 reset = 1'b1;
      #1;
      check("async_valid", resp_valid[1], 0);
      check("async_rdata", rdata[1], 0);
      check("async_err", resp_err[1], 0);
      check("async_errc", errc[1], 0);
      @(negedge clk);
      reset = 1'b0;
      repeat (6) begin
         @(negedge clk);
         check("dropped", resp_valid[1], 0);
      end
      issue(1, 0, 2'b10, 0, 32'h020, 32'h0, 32'hA5A50F0F, 0, 4, 0, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/data_mem_lat.md
# data_mem_lat

Parametrised data memory for the core with configurable response latency, byte/halfword/word access, signed-load extension and error reporting. It sits on the core's data-memory port in place of the fixed zero-latency memory. It keeps the request-acknowledge (`yumi`) / response-valid handshake, so the core's memory stage can be exercised against realistic multi-cycle cache timing. Storage is a little-endian byte array of `2**addr_width_p` bytes.

## Interface
- `addr_width_p`, default 12: byte-address width of storage; depth is `2**addr_width_p` bytes.
- `latency_p`, default 1: cycles from request acceptance to the first `resp_valid_o`; legal range is ≥1.
- `clk`, input, 1: single clock; all state changes on the posedge.
- `reset`, input, 1: one clock; reset is asynchronous and active-high.
- `req_valid_i`, input, 1: the core presents a request.
- `req_wen_i`, input, 1: 1 = store, 0 = load.
- `req_size_i`, input, 2: 00 = byte, 01 = halfword, 10 = word, 11 = reserved.
- `req_signed_i`, input, 1: for loads, 1 = sign-extend and 0 = zero-extend; ignored for stores.
- `addr_i`, input, 32: byte address.
- `wdata_i`, input, 32: store data, taken from the low bits according to size.
- `req_yumi_o`, output, 1: request accepted this cycle (combinational).
- `resp_valid_o`, output, 1: response available.
- `resp_rdata_o`, output, 32: load data, extended to 32 bits; 0 for stores and errors.
- `resp_err_o`, output, 1: request was rejected (no memory effect).
- `resp_yumi_i`, input, 1: the core consumes the response.
- `err_count_o`, output, 16: saturating count of error responses issued.

## Operation
- States: IDLE, WAIT, RESP.
- `req_yumi_o = req_valid_i & (state == IDLE)`. It is never asserted in WAIT or RESP.
- Acceptance edge:
  - All request inputs are sampled once, at the posedge where `req_yumi_o` = 1.
  - The request is classified and executed on that same edge.
  - The response is registered and held internally until it is issued.
- Error cases (any one of these gives `resp_err_o` = 1, no write, `rdata` = 0):
  - `req_size_i` = 11.
  - Misaligned address: a halfword with `addr_i[0]` = 1, or a word with `addr_i[1:0]` ≠ 0.
  - Out of bounds: `addr_i >> addr_width_p` ≠ 0.
- Store: writes `wdata_i[7:0]`, `[15:0]` or `[31:0]` to `mem[addr]` upward, little-endian.
- Load: reads 1, 2 or 4 bytes from the same bytes.
  - Bit 7 or bit 15 is replicated when `req_signed_i` = 1; otherwise the upper bits are zero-filled.
  - A word load is never extended.
- State transitions:
  - IDLE → RESP on acceptance when `latency_p` = 1.
  - IDLE → WAIT on acceptance otherwise, loading a down-counter with `latency_p - 1`.
  - WAIT decrements each cycle and goes to RESP when the counter reaches 1 (counter width is `$clog2(latency_p)`, minimum 1).
  - RESP holds `resp_valid_o` = 1 with `rdata`/`err` stable until a cycle with `resp_yumi_i` = 1, then goes to IDLE.
- `err_count_o` increments on the edge where an error response is consumed (RESP & `resp_yumi_i` & `resp_err_o`). It saturates at 0xFFFF.
- `resp_yumi_i` outside RESP is ignored.
- Reset:
  - State → IDLE; counter, `resp_valid_o`, `resp_rdata_o`, `resp_err_o` and `err_count_o` → 0.
  - A pending response is dropped.
  - Storage is not reset; contents are undefined at power-up.
  - A store accepted before reset stays committed.

## Timing
- Acceptance at posedge k gives `resp_valid_o` = 1 from posedge k + `latency_p`.
- A response consumed at posedge m allows the next acceptance no earlier than posedge m+1. Maximum throughput is one request per `latency_p + 1` cycles.
- A load issued after a store to the same address observes the stored data, because the write commits on the store's acceptance edge.
- Simultaneous `req_valid_i` and `resp_yumi_i` in RESP: the response is consumed and the request is not accepted that cycle.
- Outputs are registered, except `req_yumi_o`.

## Test plan
- Reset, then word store 0xDEADBEEF @0x010 followed by word load @0x010, `latency_p` = 1: response exactly 1 cycle after each acceptance, `rdata` = 0xDEADBEEF, `err` = 0.
- Byte load @0x013 from the same data: signed gives `rdata` = 0xFFFFFFDE, unsigned gives 0x000000DE. Halfword load @0x010 signed gives 0xFFFFBEEF.
- Errors: word store @0x011, halfword load @0x001, size 11, and word store @0x1000 (`addr_width_p` = 12). Each gives `err` = 1, `rdata` = 0, memory unchanged; `err_count_o` = 4 after all are consumed.
- `latency_p` = 4 with `resp_yumi_i` held low for 3 extra cycles: `resp_valid_o` rises 4 cycles after acceptance and `rdata` stays stable; `req_yumi_o` = 0 throughout despite `req_valid_i` = 1; the next acceptance happens the cycle after consumption.
- Assert `reset` asynchronously in WAIT: outputs go to 0 immediately with no response issued, and the next request is accepted normally.
- Force the error count to 0xFFFF, then issue one more error: `err_count_o` stays at 0xFFFF.
